ov7670_config_sequencer: RTL

//  Walks a multi-mode camera register table and issues one {reg,value} write per entry to the SCCB master.

---
 rtl/ov7670_cfg_pkg.sv | 49 ++++
 rtl/ov7670_cfg_table.sv | 45 ++++
 rtl/ov7670_config_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared constants, FSM state type and the register list common to all OV7670 init tables.
package ov7670_cfg_pkg;

    localparam logic [15:0] END_MARK    = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK  = 16'hFFF0;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_TESTBAR = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // RGB565 VGA bring-up list; soft reset at 0 is followed by the settle delay at 1.
    function automatic logic [15:0] base_entry(input logic [15:0] idx);
        logic [15:0] entry;
        case (idx)
            16'd0:   entry = 16'h1280;
            16'd1:   entry = DELAY_MARK;
            16'd2:   entry = 16'h1204;
            16'd3:   entry = 16'h1101;
            16'd4:   entry = 16'h0C00;
            16'd5:   entry = 16'h3E00;
            16'd6:   entry = 16'h8C00;
            16'd7:   entry = 16'h0400;
            16'd8:   entry = 16'h40D0;
            16'd9:   entry = 16'h3A04;
            16'd10:  entry = 16'h1418;
            16'd11:  entry = 16'h4FB3;
            16'd12:  entry = 16'h50B3;
            16'd13:  entry = 16'h5100;
            16'd14:  entry = 16'h523D;
            16'd15:  entry = 16'h53A7;
            16'd16:  entry = 16'h54E4;
            16'd17:  entry = 16'h589E;
            16'd18:  entry = 16'h3DC0;
            16'd19:  entry = 16'h704A;
            16'd20:  entry = 16'h7135;
            default: entry = END_MARK;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/ov7670_cfg_table.sv
// Multi-mode register ROM with one cycle of read latency (registered output).
module ov7670_cfg_table
    import ov7670_cfg_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_MODES = 2,
    parameter int MODE_W    = 1
) (
    input  logic              clk,
    input  logic [MODE_W-1:0] mode,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout
);

    logic [15:0] w_idx;
    logic [15:0] w_entry;

    assign w_idx = 16'(addr);

    // Per-mode table lookup; the test-bar mode only differs in the pattern registers.
    always_comb begin
        w_entry = END_MARK;
        if (int'(mode) >= NUM_MODES) begin
            w_entry = END_MARK;
        end else begin
            case (int'(mode))
                MODE_NORMAL: w_entry = base_entry(w_idx);
                MODE_TESTBAR: begin
                    case (w_idx)
                        16'd19:  w_entry = 16'h70CA;
                        16'd20:  w_entry = 16'h71B5;
                        default: w_entry = base_entry(w_idx);
                    endcase
                end
                default: w_entry = END_MARK;
            endcase
        end
    end

    // Registered ROM output.
    always_ff @(posedge clk) begin
        dout <= w_entry;
    end

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the selected OV7670 register table and hands each {reg,value} write to the SCCB master.
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int NUM_MODES    = 2,
    parameter int MODE_W       = 1,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int DLY_W        = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_reg,
    output logic [7:0]        cmd_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] entry_idx
);

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);

    state_t              r_state;
    logic [MODE_W-1:0]   r_mode;
    logic [ADDR_W-1:0]   r_idx;
    logic [DLY_W-1:0]    r_dly;
    logic [15:0]         w_entry;
    logic                w_last;

    ov7670_cfg_table #(
        .ADDR_W    (ADDR_W),
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W)
    ) u_table (
        .clk  (clk),
        .mode (r_mode),
        .addr (r_idx),
        .dout (w_entry)
    );

    assign w_last    = (r_idx == {ADDR_W{1'b1}});
    assign entry_idx = r_idx;

    // Sequencer FSM with index, delay counter and handshake output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= '0;
            r_idx     <= '0;
            r_dly     <= '0;
            cmd_valid <= 1'b0;
            cmd_reg   <= 8'h00;
            cmd_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_entry == END_MARK) begin
                        r_state <= ST_DONE;
                    end else if (w_entry == DELAY_MARK) begin
                        r_dly   <= DLY_LOAD;
                        r_state <= ST_DELAY;
                    end else begin
                        cmd_reg   <= w_entry[15:8];
                        cmd_data  <= w_entry[7:0];
                        cmd_valid <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // cmd_valid is always high here, so ready alone completes the transfer.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (w_last) begin
                            overflow <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DELAY: begin
                    if (r_dly == '0) begin
                        if (w_last) begin
                            overflow <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_dly <= r_dly - DLY_W'(1);
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
